uart_rx_fifo: RTL

Parametrised UART receiver with an integrated receive FIFO, sitting between the `uart_rx` pin and the command parser in `enigma_top`. It oversamples the line on the system clock, recovers LSB-first frames with optional parity, and queues good bytes in a first-word-fall-through FIFO. It reports framing errors, parity errors and overflow as one-cycle pulses. It replaces the single-byte receive register so the parser can absorb back-to-back command bytes such as `:` `?` without dropping any.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_rx_fifo.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the
// baud divider helper used by both the receiver and the transmitter.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4,
      ST_BRK   = 3'd5
   } rx_state_t;

   // Rounded to nearest, so 12 MHz / 115200 yields 104.
   function automatic int baud_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle, otherwise it is dropped and o_drop is raised.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == FULL_CNT);
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];

   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || i_pop);
   assign o_drop    = i_push && !w_do_push;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)
            r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (LSB first, optional parity, one stop bit) that
// queues good bytes in a sync_fifo and flags frame/parity/overflow errors.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int PARITY       = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx_in,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overflow,
   output rx_state_t                     dbg_state
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] BIT_M1   = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   rx_state_t            r_state;
   rx_state_t            w_state_nxt;
   logic [1:0]           r_sync;
   logic [1:0]           r_warm;
   logic                 r_armed;
   logic [TW-1:0]        r_tick;
   logic [BW-1:0]        r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_ok;
   logic                 r_frame_err;
   logic                 r_parity_err;
   logic                 r_overflow;
   logic                 w_rx_s;
   logic                 w_sample;
   logic                 w_push;
   logic                 w_fe;
   logic                 w_pe;
   logic                 w_drop;

   assign w_rx_s     = r_sync[1];
   assign w_sample   = (r_state == ST_START) ? (r_tick == HALF_M1) : (r_tick == BIT_M1);
   assign dbg_state  = r_state;
   assign frame_err  = r_frame_err;
   assign parity_err = r_parity_err;
   assign overflow   = r_overflow;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_fe        = 1'b0;
      w_pe        = 1'b0;
      unique case (r_state)
         ST_IDLE:  if (r_armed && !w_rx_s) w_state_nxt = ST_START;
         ST_START: if (w_sample) w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:  if (w_sample && (r_bit_cnt == LAST_BIT))
                      w_state_nxt = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
         ST_PAR:   if (w_sample) w_state_nxt = ST_STOP;
         ST_STOP:  if (w_sample) begin
                      if (w_rx_s) begin
                         w_state_nxt = ST_IDLE;
                         w_push      = r_par_ok;
                         w_pe        = !r_par_ok;
                      end else begin
                         w_state_nxt = ST_BRK;
                         w_fe        = 1'b1;
                      end
                   end
         ST_BRK:   if (w_rx_s) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // r_warm marks when the synchroniser holds real pin samples; a start is only
   // accepted after the line has been seen high, so a low line at reset is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync       <= 2'b11;
         r_warm       <= 2'b00;
         r_armed      <= 1'b0;
         r_tick       <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_par_ok     <= 1'b1;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], rx_in};
         r_warm  <= {r_warm[0], 1'b1};
         r_armed <= r_armed || (r_warm[1] && w_rx_s);
         if ((r_state == ST_IDLE) || (r_state == ST_BRK) || w_sample)
            r_tick <= '0;
         else
            r_tick <= r_tick + 1'b1;
         if (r_state == ST_IDLE) begin
            r_bit_cnt <= '0;
            r_par_ok  <= 1'b1;
         end
         if ((r_state == ST_DATA) && w_sample) begin
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if ((r_state == ST_PAR) && w_sample)
            r_par_ok <= (((^r_shift) ^ w_rx_s) == (PARITY == PAR_ODD));
         r_frame_err  <= w_fe;
         r_parity_err <= w_pe;
         r_overflow   <= w_drop;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (r_shift),
      .i_pop       (rd_en),
      .o_rd_data   (rd_data),
      .o_empty     (empty),
      .o_full      (full),
      .o_count     (count),
      .o_drop      (w_drop)
   );

endmodule
